mem_io_sequencer: RTL

- Multi-cycle sequencer between the CPU datapath's load/store decode strobes and the shared data resources: synchronous data BRAM, memory-mapped IO bus and UART program loader.
- Stalls the CPU while a BRAM read or IO handshake completes.
- Arbitrates the single BRAM port between CPU and loader.
- Sits between the decode/ALU stage and data memory / IO peripherals.

---
 rtl/mem_io_pkg.sv | 19 +
 rtl/mem_io_sequencer_io_watchdog.sv | 29 ++
 rtl/mem_io_sequencer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_io_pkg.sv
// Shared definitions for the memory/IO sequencer: state encoding, IO address match,
// and default timing parameters.
package mem_io_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StRdWait = 3'd1,
        StIoWait = 3'd2,
        StResp   = 3'd3,
        StUpg    = 3'd4
    } state_e;

    // An address decodes to IO space when its low 22 bits are all ones.
    localparam logic [31:0] IO_ADDR_MASK = 32'h003F_FFFF;

    localparam int unsigned DEF_RAM_LAT    = 1;
    localparam int unsigned DEF_IO_TIMEOUT = 255;

endpackage

// File: rtl/mem_io_sequencer_io_watchdog.sv
// Loadable down-counter that flags expiry while an IO handshake is outstanding.
// Only instantiated when MEM_IO_SEQ_IO_TIMEOUT_EN is defined.
module io_watchdog #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             run,
    output logic             expire
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (run && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // The issue cycle counts as the first wait cycle, hence the <= 1 threshold.
    assign expire = run && (cnt_q <= WIDTH'(1));

endmodule

// File: rtl/mem_io_sequencer.sv
// Load/store sequencer between CPU decode and BRAM / IO bus / UART loader.
// Optional IO timeout watchdog enabled by defining MEM_IO_SEQ_IO_TIMEOUT_EN.
module mem_io_sequencer
    import mem_io_pkg::*;
#(
    parameter int unsigned ADDR_W     = 14,
    parameter int unsigned RAM_LAT    = DEF_RAM_LAT,
    parameter int unsigned IO_TIMEOUT = DEF_IO_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              io_read,
    input  logic              io_write,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       cpu_rdata,
    output logic              stall,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              io_req,
    output logic              io_we,
    output logic [31:0]       io_wdata,
    input  logic [31:0]       io_rdata,
    input  logic              io_ack,
    input  logic              upg_active,
    input  logic              upg_valid,
    input  logic [ADDR_W-1:0] upg_addr,
    input  logic [31:0]       upg_data,
    output logic              upg_ready,
    output logic              io_timeout
);

    state_e      state_q, state_d;
    logic [1:0]  lat_q, lat_d;
    logic        io_we_q, io_we_d;
    logic [31:0] io_wdata_q, io_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        wd_load, wd_expire, tmo_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            lat_q      <= '0;
            io_we_q    <= 1'b0;
            io_wdata_q <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            lat_q      <= lat_d;
            io_we_q    <= io_we_d;
            io_wdata_q <= io_wdata_d;
            rdata_q    <= rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        io_we_d    = io_we_q;
        io_wdata_d = io_wdata_q;
        rdata_d    = rdata_q;
        stall      = 1'b0;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;
        io_req     = 1'b0;
        io_we      = 1'b0;
        io_wdata   = '0;
        upg_ready  = 1'b0;
        wd_load    = 1'b0;
        tmo_set    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (upg_active) begin
                    stall   = 1'b1;
                    state_d = StUpg;
                end else if (io_write || io_read) begin
                    io_req     = 1'b1;
                    stall      = 1'b1;
                    io_we      = io_write;
                    io_wdata   = wdata;
                    io_we_d    = io_write;
                    io_wdata_d = wdata;
                    // Same-cycle ack skips the wait state entirely.
                    if (io_ack) begin
                        if (!io_write) rdata_d = io_rdata;
                        state_d = StResp;
                    end else begin
                        wd_load = 1'b1;
                        state_d = StIoWait;
                    end
                end else if (mem_write) begin
                    ram_en    = 1'b1;
                    ram_we    = 1'b1;
                    ram_addr  = addr[ADDR_W+1:2];
                    ram_wdata = wdata;
                end else if (mem_read) begin
                    ram_en   = 1'b1;
                    ram_addr = addr[ADDR_W+1:2];
                    stall    = 1'b1;
                    lat_d    = 2'd1;
                    state_d  = StRdWait;
                end
            end
            StRdWait: begin
                stall = 1'b1;
                if (lat_q == 2'(RAM_LAT)) begin
                    rdata_d = ram_rdata;
                    state_d = StResp;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            StIoWait: begin
                io_req   = 1'b1;
                stall    = 1'b1;
                io_we    = io_we_q;
                io_wdata = io_wdata_q;
                if (io_ack) begin
                    if (!io_we_q) rdata_d = io_rdata;
                    state_d = StResp;
                end else if (wd_expire) begin
                    if (!io_we_q) rdata_d = '0;
                    tmo_set = 1'b1;
                    state_d = StResp;
                end
            end
            StResp: begin
                lat_d   = '0;
                state_d = StIdle;
            end
            StUpg: begin
                stall     = 1'b1;
                upg_ready = 1'b1;
                if (upg_valid) begin
                    ram_en    = 1'b1;
                    ram_we    = 1'b1;
                    ram_addr  = upg_addr;
                    ram_wdata = upg_data;
                end
                if (!upg_active) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Reset silences every strobe in the cycle it is applied.
        if (rst) begin
            stall     = 1'b0;
            ram_en    = 1'b0;
            ram_we    = 1'b0;
            ram_addr  = '0;
            ram_wdata = '0;
            io_req    = 1'b0;
            io_we     = 1'b0;
            io_wdata  = '0;
            upg_ready = 1'b0;
        end
    end

    assign cpu_rdata = rdata_q;

`ifdef MEM_IO_SEQ_IO_TIMEOUT_EN
    logic tmo_q;

    io_watchdog #(
        .WIDTH(16)
    ) u_io_watchdog (
        .clk      (clk),
        .rst      (rst),
        .load     (wd_load),
        .load_val (16'(IO_TIMEOUT - 1)),
        .run      (state_q == StIoWait),
        .expire   (wd_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= 1'b0;
        end else if (tmo_set) begin
            tmo_q <= 1'b1;
        end
    end

    assign io_timeout = tmo_q;

    logic unused_sig;
    assign unused_sig = ^{addr[31:ADDR_W+2], addr[1:0]};
`else
    assign wd_expire  = 1'b0;
    assign io_timeout = 1'b0;

    logic unused_sig;
    assign unused_sig = ^{addr[31:ADDR_W+2], addr[1:0], wd_load, tmo_set, 16'(IO_TIMEOUT)};
`endif

endmodule
